// File: rtl/shift_unit_pkg.sv
// rtl/shift_unit_pkg.sv - shared op and state encodings for the sequential shift unit
package shift_unit_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2,
        SH_ROR = 2'd3
    } sh_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sh_state_e;

endpackage

// File: rtl/shift_unit_step.sv
// rtl/shift_unit_step.sv - one partial shift of k (0..STEP) positions; rotate only with SHIFT_UNIT_ROTATE_EN
module shift_unit_step #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [KW-1:0]    k_i,
    input  logic [1:0]       op_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);
    import shift_unit_pkg::*;

    localparam logic [WIDTH-1:0] ONES = '1;

`ifdef SHIFT_UNIT_ROTATE_EN
    logic [WIDTH-1:0] rot_w;

    // Rotate-right: shifting a doubled copy pulls the low bits into the top
    assign rot_w = WIDTH'({data_i, data_i} >> k_i);
`endif

    // Select shift flavour; SRA ORs in the latched sign over the vacated MSBs
    always_comb begin
        data_o = data_i;
        case (op_i)
            SH_SLL: data_o = data_i << k_i;
            SH_SRL: data_o = data_i >> k_i;
            SH_SRA: data_o = (data_i >> k_i) | (fill_i ? ~(ONES >> k_i) : '0);
`ifdef SHIFT_UNIT_ROTATE_EN
            SH_ROR: data_o = rot_w;
`else
            SH_ROR: data_o = data_i >> k_i;
`endif
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// rtl/shift_unit_seq.sv - multi-cycle shift unit, STEP bits per clock, handshaked (macro SHIFT_UNIT_ROTATE_EN)
module shift_unit_seq #(
    parameter int  WIDTH = 32,
    parameter int  STEP  = 4,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    import shift_unit_pkg::*;

    localparam int           KW     = $clog2(STEP + 1);
    localparam logic [SHW:0] STEP_W = (SHW + 1)'(STEP);

    sh_state_e        state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic [1:0]       op_q, op_d;
    logic             sign_q, sign_d;

    logic [KW-1:0]    step_k;
    logic [SHW-1:0]   step_rem;
    logic [WIDTH-1:0] step_out;

    // Amount for this cycle is min(STEP, remaining); remaining after the step follows
    always_comb begin
        if ({1'b0, rem_q} > STEP_W) begin
            step_k   = KW'(STEP);
            step_rem = rem_q - SHW'(STEP);
        end else begin
            step_k   = KW'(rem_q);
            step_rem = '0;
        end
    end

    shift_unit_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .data_i (data_q),
        .k_i    (step_k),
        .op_i   (op_q),
        .fill_i (sign_q),
        .data_o (step_out)
    );

    // Next-state and datapath updates: accept in IDLE, shift in SHIFT, hold in DONE
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        op_d    = op_q;
        sign_d  = sign_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    rem_d   = in_shamt;
                    op_d    = in_op;
                    sign_d  = in_data[WIDTH-1];
                    state_d = (in_shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                data_d = step_out;
                rem_d  = step_rem;
                if (step_rem == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and working registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            op_q    <= 2'd0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// tb/tb_shift_unit_seq.sv - scoreboard bench for shift_unit_seq with randomized traffic
module tb_shift_unit_seq;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [SHW-1:0]   in_shamt = '0;
    logic [1:0]       in_op = 2'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    shift_unit_seq #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    logic rdy_rand  = 1'b0;
    logic rdy_force = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input int s);
        case (op)
            2'd0: return d << s;
            2'd1: return d >> s;
            2'd2: return 32'($signed(d) >>> s);
            default: begin
`ifdef SHIFT_UNIT_ROTATE_EN
                if (s == 0) return d;
                return (d >> s) | (d << (32 - s));
`else
                return d >> s;
`endif
            end
        endcase
    endfunction

    function automatic int lat(input int s);
        return (s + STEP - 1) / STEP;
    endfunction

    // out_ready driver: either a fixed level or a coin flip per cycle
    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    logic             prev_ov = 1'b0;
    logic             prev_or = 1'b0;
    logic [WIDTH-1:0] prev_od = '0;

    // Monitor: tracks busy/in_ready against outstanding work, latency, stall stability, results
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_track", {31'b0, busy}, {31'b0, sbq.size() > 0});
            check("in_ready_track", {31'b0, in_ready}, {31'b0, sbq.size() == 0});
            if (prev_ov && !prev_or) begin
                check("stall_valid", {31'b0, out_valid}, 32'd1);
                check("stall_data", out_data, prev_od);
            end
            if (out_valid && !prev_ov) begin
                if (sbq.size() == 0) check("spurious_valid", 32'd1, 32'd0);
                else check("latency_edge", cyc, sbq[0].due);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) check("unexpected_result", 32'd1, 32'd0);
                else begin
                    check("result", out_data, sbq[0].data);
                    void'(sbq.pop_front());
                end
            end
            prev_ov = out_valid;
            prev_or = out_ready;
            prev_od = out_data;
        end else begin
            prev_ov = 1'b0;
            prev_or = 1'b0;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] d, input int s);
        int w = 0;
        while (!in_ready && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            check("issue_timeout", 32'd0, 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = s[SHW-1:0];
        @(posedge clk); #1;
        sbq.push_back('{model(op, d, s), cyc + lat(s)});
        in_valid = 1'b0;
        in_data  = $urandom;
        in_shamt = SHW'($urandom_range(0, 31));
        in_op    = 2'($urandom_range(0, 3));
    endtask

    task automatic drain();
        int w = 0;
        while (sbq.size() > 0 && w < 400) begin
            @(posedge clk); #1;
            w++;
        end
        if (sbq.size() > 0) begin
            check("drain_timeout", 32'd0, 32'd1);
            sbq.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(2'd0, 32'h0000_0001, 2);
        drain();
        check("sll_1_by_2_model", model(2'd0, 32'h1, 2), 32'h0000_0004);

        issue(2'd2, 32'h8000_0000, 31);
        issue(2'd1, 32'h8000_0000, 31);
        drain();

        // Zero shift with in_valid held through a 5-cycle output stall
        rdy_force = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_op    = 2'($urandom_range(0, 3));
        in_data  = 32'hDEAD_BEEF;
        in_shamt = '0;
        @(posedge clk); #1;
        sbq.push_back('{32'hDEAD_BEEF, cyc});
        repeat (5) begin
            @(posedge clk); #1;
            check("held_valid_no_accept", {31'b0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        rdy_force = 1'b1;
        drain();
        check("ready_after_release", {31'b0, in_ready}, 32'd1);

        issue(2'd3, 32'h0000_0001, 1);
        drain();

        // Reset in the middle of a long shift
        issue(2'd1, $urandom, 20);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        sbq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(2'd0, 32'h0000_0001, 4);
        drain();

        // Randomized traffic with random back-pressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 200; i++) begin
            issue(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 31));
        end
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        drain();
        repeat (2) begin @(posedge clk); #1; end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
